// File: rtl/attn_pkg.sv
// Shared sizing defaults and FSM encoding for the attention result checker.
package attn_pkg;

   localparam int unsigned DATA_W = 16;
   localparam int unsigned N_ELEM = 32;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CHECK = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/attn_result_checker_if.sv
// Expected-image write port, result bus and check-result outputs of the checker.
interface attn_result_checker_if
   import attn_pkg::*;
#(
   parameter int unsigned DATA_W = attn_pkg::DATA_W,
   parameter int unsigned N_ELEM = attn_pkg::N_ELEM
);
   localparam int unsigned IDX_W = $clog2(N_ELEM);
   localparam int unsigned CNT_W = $clog2(N_ELEM + 1);

   logic                     exp_wr;
   logic [IDX_W-1:0]         exp_addr;
   logic [DATA_W-1:0]        exp_data;
   logic [N_ELEM*DATA_W-1:0] final_res;
   logic                     all_done;

   logic                     busy;
   logic                     done;
   logic                     pass;
   logic [CNT_W-1:0]         err_count;
   logic                     first_err_valid;
   logic [IDX_W-1:0]         first_err_idx;
   logic [DATA_W-1:0]        first_err_exp;
   logic [DATA_W-1:0]        first_err_act;
   logic [DATA_W-1:0]        max_err;

   modport master (
      output exp_wr, exp_addr, exp_data, final_res, all_done,
      input  busy, done, pass, err_count, first_err_valid,
             first_err_idx, first_err_exp, first_err_act, max_err
   );

   modport slave (
      input  exp_wr, exp_addr, exp_data, final_res, all_done,
      output busy, done, pass, err_count, first_err_valid,
             first_err_idx, first_err_exp, first_err_act, max_err
   );

endinterface

// File: rtl/attn_lane_cmp.sv
// One comparison lane: saturated absolute difference of raw codes and tolerance test.
module attn_lane_cmp
   import attn_pkg::*;
#(
   parameter int unsigned DATA_W = attn_pkg::DATA_W,
   parameter int unsigned TOL    = 0
)(
   input  logic [DATA_W-1:0] act,
   input  logic [DATA_W-1:0] exp,
   output logic              mismatch,
   output logic [DATA_W-1:0] diff
);
   localparam logic [DATA_W:0] TOL_W = (DATA_W + 1)'(TOL);

   logic [DATA_W:0] wide;

   always_comb begin
      if (act >= exp) wide = {1'b0, act} - {1'b0, exp};
      else            wide = {1'b0, exp} - {1'b0, act};
      diff     = wide[DATA_W] ? '1 : wide[DATA_W-1:0];
      mismatch = ({1'b0, diff} > TOL_W);
   end

endmodule

// File: rtl/attn_result_checker.sv
// Scoreboard: snapshots the core result bus on all_done and compares LANES
// elements per cycle against a writable expected image.
module attn_result_checker
   import attn_pkg::*;
#(
   parameter int unsigned DATA_W      = attn_pkg::DATA_W,
   parameter int unsigned N_ELEM      = attn_pkg::N_ELEM,
   parameter int unsigned LANES       = 4,
   parameter int unsigned TOL         = 0,
   parameter int unsigned STOP_ON_ERR = 0
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   attn_result_checker_if.slave  chk
);
   localparam int unsigned IDX_W  = $clog2(N_ELEM);
   localparam int unsigned CNT_W  = $clog2(N_ELEM + 1);
   localparam int unsigned N_GRP  = N_ELEM / LANES;
   localparam int unsigned PTR_W  = (N_GRP > 1) ? $clog2(N_GRP) : 1;
   localparam int unsigned LID_W  = (LANES > 1) ? $clog2(LANES) : 1;
   localparam int unsigned LCNT_W = $clog2(LANES + 1);

   if (N_ELEM % LANES != 0) begin : g_bad_lanes
      $error("attn_result_checker: LANES must divide N_ELEM");
   end

   state_t            state;
   logic [PTR_W-1:0]  ptr;
   logic [DATA_W-1:0] exp_mem [N_ELEM];
   logic [DATA_W-1:0] cap     [N_ELEM];

   logic              busy_q;
   logic              done_q;
   logic              pass_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              fev_q;
   logic [IDX_W-1:0]  fidx_q;
   logic [DATA_W-1:0] fexp_q;
   logic [DATA_W-1:0] fact_q;
   logic [DATA_W-1:0] max_q;

   logic              accept;
   logic              mem_we;
   logic              last_grp;

   logic [IDX_W-1:0]  lane_idx  [LANES];
   logic [DATA_W-1:0] lane_act  [LANES];
   logic [DATA_W-1:0] lane_exp  [LANES];
   logic [DATA_W-1:0] lane_diff [LANES];
   logic [LANES-1:0]  lane_mis;

   logic              grp_hit;
   logic [LID_W-1:0]  grp_first;
   logic [LCNT_W-1:0] grp_errs;
   logic [DATA_W-1:0] grp_max;

   assign accept   = en && (state == ST_IDLE) && chk.all_done;
   assign mem_we   = en && (state == ST_IDLE) && chk.exp_wr;
   assign last_grp = (ptr == PTR_W'(N_GRP - 1));

   // Image is deliberately not reset so it survives an aborted check.
   always_ff @(posedge clk) begin
      if (!rst && mem_we)
         exp_mem[chk.exp_addr] <= chk.exp_data;
   end

   always_ff @(posedge clk) begin
      if (!rst && accept)
         for (int unsigned i = 0; i < N_ELEM; i++)
            cap[i] <= chk.final_res[i*DATA_W +: DATA_W];
   end

   always_comb begin
      for (int unsigned l = 0; l < LANES; l++) begin
         lane_idx[l] = IDX_W'(ptr * LANES + l);
         lane_act[l] = cap[lane_idx[l]];
         lane_exp[l] = exp_mem[lane_idx[l]];
      end
   end

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      attn_lane_cmp #(
         .DATA_W (DATA_W),
         .TOL    (TOL)
      ) u_cmp (
         .act      (lane_act[g]),
         .exp      (lane_exp[g]),
         .mismatch (lane_mis[g]),
         .diff     (lane_diff[g])
      );
   end

   // Lowest lane wins the first-error slot; count and worst diff cover all lanes.
   always_comb begin
      grp_hit   = 1'b0;
      grp_first = '0;
      grp_errs  = '0;
      grp_max   = '0;
      for (int unsigned l = 0; l < LANES; l++) begin
         grp_errs = grp_errs + LCNT_W'(lane_mis[l]);
         if (lane_diff[l] > grp_max)
            grp_max = lane_diff[l];
         if (lane_mis[l] && !grp_hit) begin
            grp_hit   = 1'b1;
            grp_first = LID_W'(l);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= ST_IDLE;
         ptr    <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         pass_q <= 1'b0;
         cnt_q  <= '0;
         fev_q  <= 1'b0;
         fidx_q <= '0;
         fexp_q <= '0;
         fact_q <= '0;
         max_q  <= '0;
      end else if (en) begin
         unique case (state)
            ST_IDLE: begin
               done_q <= 1'b0;
               if (chk.all_done) begin
                  state  <= ST_CHECK;
                  busy_q <= 1'b1;
                  ptr    <= '0;
                  pass_q <= 1'b0;
                  cnt_q  <= '0;
                  fev_q  <= 1'b0;
                  fidx_q <= '0;
                  fexp_q <= '0;
                  fact_q <= '0;
                  max_q  <= '0;
               end
            end
            ST_CHECK: begin
               cnt_q <= cnt_q + CNT_W'(grp_errs);
               if (grp_max > max_q)
                  max_q <= grp_max;
               if (grp_hit && !fev_q) begin
                  fev_q  <= 1'b1;
                  fidx_q <= lane_idx[grp_first];
                  fexp_q <= lane_exp[grp_first];
                  fact_q <= lane_act[grp_first];
               end
               ptr <= ptr + 1'b1;
               if (last_grp || (STOP_ON_ERR != 0 && grp_hit)) begin
                  state  <= ST_DONE;
                  busy_q <= 1'b0;
               end
            end
            ST_DONE: begin
               done_q <= 1'b1;
               pass_q <= (cnt_q == '0);
               state  <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign chk.busy            = busy_q;
   assign chk.done            = done_q;
   assign chk.pass            = pass_q;
   assign chk.err_count       = cnt_q;
   assign chk.first_err_valid = fev_q;
   assign chk.first_err_idx   = fidx_q;
   assign chk.first_err_exp   = fexp_q;
   assign chk.first_err_act   = fact_q;
   assign chk.max_err         = max_q;

endmodule

// File: doc/attn_result_checker.md
# attn_result_checker

Synthesizable self-checking scoreboard for attention-core outputs. It holds an expected-result image loaded through a write port, captures the flat result bus from a `pe_*_top`-style core on its `all_done` strobe, and compares LANES elements per cycle against the image. Comparison is exact or tolerance-based. It reports pass/fail, mismatch count, first-mismatch details and worst-case error. It sits beside the attention core in both simulation benches and on-chip test wrappers, and replaces ad-hoc `$display`/`$stop` checking loops.

## Interface
- DATA_W, 16, element width in bits
- N_ELEM, 32, elements per result vector
- LANES, 4, elements compared per cycle; must divide N_ELEM
- TOL, 0, maximum allowed absolute difference of raw codes; 0 = exact match
- STOP_ON_ERR, 0, 1 = finish at the end of the first cycle that contains a mismatch
- IDX_W, $clog2(N_ELEM), index width (derived)
- CNT_W, $clog2(N_ELEM+1), count width (derived)

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset; synchronous, active-high
- en  in  1  global enable; when low, all state and outputs hold
- exp_wr  in  1  expected-image write strobe
- exp_addr  in  IDX_W  element index to write
- exp_data  in  DATA_W  expected element value
- final_res  in  N_ELEM*DATA_W  result bus; element i is `[i*DATA_W +: DATA_W]`
- all_done  in  1  result-valid strobe from the core
- busy  out  1  high in CHECK
- done  out  1  one-cycle pulse when a check finishes
- pass  out  1  valid from `done` until the next accept; 1 means err_count==0
- err_count  out  CNT_W  number of mismatched elements
- first_err_valid  out  1  a mismatch was recorded
- first_err_idx  out  IDX_W  lowest mismatched index
- first_err_exp  out  DATA_W  expected value at first_err_idx
- first_err_act  out  DATA_W  actual value at first_err_idx
- max_err  out  DATA_W  largest absolute difference seen over compared elements

## Operation
- States: IDLE, CHECK, DONE.
- Reset: state IDLE. All outputs 0: busy, done, pass, err_count, first_err_*, max_err. Expected memory contents are not cleared.
- IDLE:
  - `exp_wr` writes `exp_data` to `exp_addr`.
  - `all_done` with `en` high is an accept: snapshot `final_res` into the capture register, clear err_count, first_err_*, max_err and pass, clear the lane pointer, go to CHECK.
  - `exp_wr` and `all_done` in the same cycle: the write lands first. The written element is the value compared.
- CHECK:
  - Each cycle compares elements `ptr*LANES .. ptr*LANES+LANES-1`.
  - Per lane: `diff = |act - exp|` on unsigned DATA_W codes, computed at DATA_W+1 bits and saturated to DATA_W. Mismatch when `diff > TOL`.
  - err_count adds the number of mismatching lanes.
  - max_err updates to the largest diff.
  - If first_err_valid is 0, latch the lowest-index mismatching lane of this cycle.
  - Advance the pointer. After the last group, go to DONE.
  - With STOP_ON_ERR=1, go to DONE after the first cycle containing a mismatch.
  - `exp_wr` and `all_done` are ignored and dropped.
- DONE: for one cycle, `done`=1 and `pass = (err_count==0)`; then IDLE. `all_done` in DONE is ignored.
- `en` low stalls in any state. `done` stays high while stalled in DONE.
- `rst` mid-check aborts: IDLE, no `done` pulse.

## Timing
- Accept at edge k. CHECK occupies edges k+1 .. k+N_ELEM/LANES. `done` is high for the cycle after edge k+N_ELEM/LANES+1. Defaults: 8 CHECK cycles, `done` after edge k+9.
- Result outputs are registered and update at the edge that completes each CHECK cycle. They are final when `done` rises and hold until the next accept.
- `busy` is registered: high exactly during CHECK.
- Expected-memory write latency is 1 cycle. Reads are from a combinational register-array read.
- Earliest back-to-back accept: the cycle after DONE.

## Structure
- Shared package/header `attn_pkg` holds DATA_W, N_ELEM, and the state encoding constants `ST_IDLE=2'd0`, `ST_CHECK=2'd1`, `ST_DONE=2'd2`.
- Sub-module `attn_lane_cmp`: combinational, one per lane. Inputs are act, exp and TOL; outputs are mismatch and saturated diff. The top instantiates it LANES times and does the lowest-index priority encode.

## Test plan
- All-match:
  - Stimulus: load 32 expected values 0x3C00+i, drive the identical bus, pulse `all_done`.
  - Required response: `done` after edge k+9; pass=1, err_count=0, first_err_valid=0, max_err=0.
- Two mismatches:
  - Stimulus: corrupt element 5 to 0x3C07 (exp 0x3C05) and element 21 by +0x10.
  - Required response: err_count=2, first_err_idx=5, first_err_exp=0x3C05, first_err_act=0x3C07, max_err=0x0010, pass=0.
- Tolerance:
  - Stimulus: TOL=2 build, element 9 off by 2, element 10 off by 3.
  - Required response: err_count=1, first_err_idx=10, max_err=3.
- STOP_ON_ERR=1:
  - Stimulus: mismatch at element 13, which is in group 3.
  - Required response: `done` after edge k+5, err_count=1, first_err_idx=13.
- Stall and abort:
  - Stimulus (stall): drop `en` for 3 cycles mid-CHECK.
  - Required response: `done` delayed by exactly 3, results unchanged.
  - Stimulus (abort): assert `rst` mid-CHECK.
  - Required response: no `done`, all outputs 0; a later accept checks correctly with the preserved expected image.
- Ignored events: `all_done` and `exp_wr` during CHECK have no effect on the counts or the expected image.
